// File: rtl/volatility_sched.sv
// volatility_sched: round-robin arbiter feeding one volatility unit, with per-stock hazard lockout.
module volatility_sched #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_STOCKS = 4,
  parameter int NUM_REQ = 2,
  parameter int HAZARD_CYCLES = 3,
  localparam int SW = $clog2(NUM_STOCKS),
  localparam int GW = $clog2(NUM_REQ)
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic                          i_pause,
  input  logic [NUM_REQ-1:0]            i_req_valid,
  output logic [NUM_REQ-1:0]            o_req_ready,
  input  logic [NUM_REQ*SW-1:0]         i_req_stock_id,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_best_ask,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_best_bid,
  output logic                          o_data_valid,
  output logic [SW-1:0]                 o_stock_id,
  output logic [DATA_WIDTH-1:0]         o_best_ask,
  output logic [DATA_WIDTH-1:0]         o_best_bid,
  output logic [GW-1:0]                 o_grant_id,
  output logic [NUM_STOCKS-1:0]         o_stock_locked
);
  localparam int NS2 = 1 << SW;
  logic [NUM_STOCKS-1:0] locked;
  logic [NS2-1:0] blocked;
  logic [NUM_REQ-1:0] elig;
  logic [GW-1:0] ptr, gid, idx;
  logic grant;
  logic [SW-1:0] g_sid;
  // ids beyond NUM_STOCKS decode to a permanently blocked slot
  for (genvar s = 0; s < NS2; s++) begin : g_blk
    if (s < NUM_STOCKS) begin : g_real
      assign blocked[s] = locked[s];
    end else begin : g_pad
      assign blocked[s] = 1'b1;
    end
  end
  for (genvar r = 0; r < NUM_REQ; r++) begin : g_elig
    assign elig[r] = i_req_valid[r] && !blocked[i_req_stock_id[r*SW +: SW]] && !i_pause && !i_reset;
  end
  always_comb begin
    o_req_ready = '0;
    grant = 1'b0;
    gid = '0;
    idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = GW'((int'(ptr) + k) % NUM_REQ);
      if (!grant && elig[idx]) begin
        grant = 1'b1;
        gid = idx;
      end
    end
    o_req_ready[gid] = grant;
  end
  assign g_sid = i_req_stock_id[gid*SW +: SW];
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      ptr <= '0;
      o_data_valid <= 1'b0;
      o_stock_id <= '0;
      o_best_ask <= '0;
      o_best_bid <= '0;
      o_grant_id <= '0;
    end else begin
      o_data_valid <= grant;
      if (grant) begin
        ptr <= (int'(gid) == NUM_REQ - 1) ? '0 : gid + 1'b1;
        o_stock_id <= g_sid;
        o_best_ask <= i_req_best_ask[gid*DATA_WIDTH +: DATA_WIDTH];
        o_best_bid <= i_req_best_bid[gid*DATA_WIDTH +: DATA_WIDTH];
        o_grant_id <= gid;
      end
    end
  end
  if (HAZARD_CYCLES > 0) begin : g_lock
    localparam int CW = $clog2(HAZARD_CYCLES + 1);
    logic [CW-1:0] cnt [NUM_STOCKS];
    always_ff @(posedge i_clk) begin
      for (int i = 0; i < NUM_STOCKS; i++)
        if (i_reset) cnt[i] <= '0;
        else if (grant && int'(g_sid) == i) cnt[i] <= CW'(HAZARD_CYCLES);
        else if (cnt[i] != '0) cnt[i] <= cnt[i] - 1'b1;
    end
    always_comb begin
      locked = '0;
      for (int i = 0; i < NUM_STOCKS; i++) locked[i] = cnt[i] != '0;
    end
  end else begin : g_nolock
    assign locked = '0;
  end
  assign o_stock_locked = locked;
endmodule

// File: tb/tb_volatility_sched.sv
// tb_volatility_sched: directed per-cycle vector table plus a hazard-spacing sequence.
module tb_volatility_sched;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pause = 1'b0;
  logic [1:0] valid = '0;
  logic [1:0] ready;
  logic [3:0] sid_bus = '0;
  logic [63:0] ask_bus = '0, bid_bus = '0;
  logic dv;
  logic [1:0] sid;
  logic [31:0] ask, bid;
  logic gid;
  logic [3:0] lock;
  int checks = 0, failures = 0;
  int gap;

  typedef struct {
    logic rst, pause;
    logic [1:0] valid, s0, s1;
    logic [31:0] a0, b0, a1, b1;
    logic [1:0] rdy;
    logic dv;
    logic [1:0] sid;
    logic [31:0] ask, bid;
    logic gid;
    logic [3:0] lock;
  } vec_t;
  vec_t vecs[$];

  volatility_sched dut (
    .i_clk(clk), .i_reset(rst), .i_pause(pause),
    .i_req_valid(valid), .o_req_ready(ready),
    .i_req_stock_id(sid_bus), .i_req_best_ask(ask_bus), .i_req_best_bid(bid_bus),
    .o_data_valid(dv), .o_stock_id(sid), .o_best_ask(ask), .o_best_bid(bid),
    .o_grant_id(gid), .o_stock_locked(lock)
  );

  always #5 clk = ~clk;

  task automatic add(input int r, input int p, input int v, input int s0, input int a0, input int b0,
                     input int s1, input int a1, input int b1, input int rdy, input int edv,
                     input int esid, input int eask, input int ebid, input int egid, input int elock);
    vec_t t;
    t.rst = 1'(r); t.pause = 1'(p); t.valid = 2'(v);
    t.s0 = 2'(s0); t.a0 = 32'(a0); t.b0 = 32'(b0);
    t.s1 = 2'(s1); t.a1 = 32'(a1); t.b1 = 32'(b1);
    t.rdy = 2'(rdy); t.dv = 1'(edv); t.sid = 2'(esid);
    t.ask = 32'(eask); t.bid = 32'(ebid); t.gid = 1'(egid); t.lock = 4'(elock);
    vecs.push_back(t);
  endtask

  task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s row %0d: got %0d expected %0d", name, row, act, exp);
    end
  endtask

  initial begin
    // reset state
    add(1,0,0, 0,0,0, 0,0,0, 0, 0,0,0,0,0, 4'b0000);
    // single requester, stock 2
    add(0,0,1, 2,105,100, 0,0,0, 1, 0,0,0,0,0, 4'b0000);
    add(0,0,0, 0,0,0, 0,0,0, 0, 1,2,105,100,0, 4'b0100);
    add(0,0,0, 0,0,0, 0,0,0, 0, 0,2,105,100,0, 4'b0100);
    add(0,0,0, 0,0,0, 0,0,0, 0, 0,2,105,100,0, 4'b0100);
    add(0,0,0, 0,0,0, 0,0,0, 0, 0,2,105,100,0, 4'b0000);
    add(1,0,0, 0,0,0, 0,0,0, 0, 0,2,105,100,0, 4'b0000);
    // round robin, 8 grants
    add(0,0,3, 0,1000,500, 1,1001,501, 1, 0,0,0,0,0, 4'b0000);
    add(0,0,3, 2,1002,502, 1,1001,501, 2, 1,0,1000,500,0, 4'b0001);
    add(0,0,3, 2,1002,502, 3,1003,503, 1, 1,1,1001,501,1, 4'b0011);
    add(0,0,3, 0,1004,504, 3,1003,503, 2, 1,2,1002,502,0, 4'b0111);
    add(0,0,3, 0,1004,504, 1,1005,505, 1, 1,3,1003,503,1, 4'b1110);
    add(0,0,3, 2,1006,506, 1,1005,505, 2, 1,0,1004,504,0, 4'b1101);
    add(0,0,3, 2,1006,506, 3,1007,507, 1, 1,1,1005,505,1, 4'b1011);
    add(0,0,2, 0,0,0, 3,1007,507, 2, 1,2,1006,506,0, 4'b0111);
    add(0,0,0, 0,0,0, 0,0,0, 0, 1,3,1007,507,1, 4'b1110);
    add(1,0,0, 0,0,0, 0,0,0, 0, 0,3,1007,507,1, 4'b1100);
    // same-stock hazard on stock 3
    add(0,0,3, 3,11,10, 3,21,20, 1, 0,0,0,0,0, 4'b0000);
    add(0,0,2, 0,0,0, 3,21,20, 0, 1,3,11,10,0, 4'b1000);
    add(0,0,2, 0,0,0, 3,21,20, 0, 0,3,11,10,0, 4'b1000);
    add(0,0,2, 0,0,0, 3,21,20, 0, 0,3,11,10,0, 4'b1000);
    add(0,0,2, 0,0,0, 3,21,20, 2, 0,3,11,10,0, 4'b0000);
    add(0,0,0, 0,0,0, 0,0,0, 0, 1,3,21,20,1, 4'b1000);
    add(0,0,0, 0,0,0, 0,0,0, 0, 0,3,21,20,1, 4'b1000);
    // mixed hazard
    add(0,0,1, 1,31,30, 0,0,0, 1, 0,3,21,20,1, 4'b1000);
    add(0,0,3, 1,33,32, 2,41,40, 2, 1,1,31,30,0, 4'b0010);
    add(0,0,1, 1,33,32, 0,0,0, 0, 1,2,41,40,1, 4'b0110);
    add(0,0,1, 1,33,32, 0,0,0, 0, 0,2,41,40,1, 4'b0110);
    add(0,0,1, 1,33,32, 0,0,0, 1, 0,2,41,40,1, 4'b0100);
    add(0,0,0, 0,0,0, 0,0,0, 0, 1,1,33,32,0, 4'b0010);
    add(1,0,0, 0,0,0, 0,0,0, 0, 0,1,33,32,0, 4'b0010);
    // pause
    add(0,0,3, 0,51,50, 1,61,60, 1, 0,0,0,0,0, 4'b0000);
    add(0,0,3, 2,53,52, 1,61,60, 2, 1,0,51,50,0, 4'b0001);
    add(0,1,3, 2,53,52, 3,63,62, 0, 1,1,61,60,1, 4'b0011);
    add(0,1,3, 2,53,52, 3,63,62, 0, 0,1,61,60,1, 4'b0011);
    add(0,1,3, 2,53,52, 3,63,62, 0, 0,1,61,60,1, 4'b0010);
    add(0,1,3, 2,53,52, 3,63,62, 0, 0,1,61,60,1, 4'b0000);
    add(0,0,3, 2,53,52, 3,63,62, 1, 0,1,61,60,1, 4'b0000);
    add(0,0,2, 0,0,0, 3,63,62, 2, 1,2,53,52,0, 4'b0100);
    add(0,0,0, 0,0,0, 0,0,0, 0, 1,3,63,62,1, 4'b1100);
    // reset mid-operation
    add(0,0,2, 0,0,0, 1,81,80, 2, 0,3,63,62,1, 4'b1100);
    add(0,0,1, 0,71,70, 0,0,0, 1, 1,1,81,80,1, 4'b1010);
    add(1,0,3, 0,75,74, 3,85,84, 0, 1,0,71,70,0, 4'b0011);
    add(0,0,3, 0,75,74, 3,85,84, 1, 0,0,0,0,0, 4'b0000);
    add(0,0,2, 0,0,0, 3,85,84, 2, 1,0,75,74,0, 4'b0001);
    add(0,0,0, 0,0,0, 0,0,0, 0, 1,3,85,84,1, 4'b1001);
    add(0,0,0, 0,0,0, 0,0,0, 0, 0,3,85,84,1, 4'b1001);

    repeat (2) @(posedge clk);
    foreach (vecs[i]) begin
      @(posedge clk);
      #1;
      rst = vecs[i].rst; pause = vecs[i].pause; valid = vecs[i].valid;
      sid_bus = {vecs[i].s1, vecs[i].s0};
      ask_bus = {vecs[i].a1, vecs[i].a0};
      bid_bus = {vecs[i].b1, vecs[i].b0};
      @(negedge clk);
      chk("ready", i, 32'(ready), 32'(vecs[i].rdy));
      chk("data_valid", i, 32'(dv), 32'(vecs[i].dv));
      chk("stock_id", i, 32'(sid), 32'(vecs[i].sid));
      chk("best_ask", i, ask, vecs[i].ask);
      chk("best_bid", i, bid, vecs[i].bid);
      chk("grant_id", i, 32'(gid), 32'(vecs[i].gid));
      chk("stock_locked", i, 32'(lock), 32'(vecs[i].lock));
    end

    // back-to-back same stock: next grant exactly HAZARD_CYCLES+1 cycles later
    @(posedge clk);
    #1;
    rst = 0; pause = 0; valid = 2'b01;
    sid_bus = {2'd0, 2'd2}; ask_bus = {32'd0, 32'd91}; bid_bus = {32'd0, 32'd90};
    @(negedge clk);
    chk("seq_first_ready", -1, 32'(ready), 32'd1);
    @(posedge clk);
    #1;
    ask_bus = {32'd0, 32'd93}; bid_bus = {32'd0, 32'd92};
    @(negedge clk);
    chk("seq_issue_valid", -1, 32'(dv), 32'd1);
    chk("seq_issue_ask", -1, ask, 32'd91);
    gap = 1;
    while (!ready[0] && gap < 10) begin
      @(negedge clk);
      gap++;
    end
    chk("seq_gap", -1, 32'(gap), 32'd4);
    @(posedge clk);
    #1;
    valid = 2'b00;
    @(negedge clk);
    chk("seq_second_valid", -1, 32'(dv), 32'd1);
    chk("seq_second_ask", -1, ask, 32'd93);
    chk("seq_second_bid", -1, bid, 32'd92);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/volatility_sched.md
Name: volatility_sched

Overview:
Round-robin scheduler that shares one volatility datapath between NUM_REQ market-data requesters (e.g. per-exchange feed handlers). Each cycle it grants at most one eligible request and forwards stock_id/best_ask/best_bid to the volatility unit as a registered, single-cycle-valid update. It blocks same-stock read-modify-write hazards by locking a stock for HAZARD_CYCLES cycles after each issue. It sits directly upstream of the volatility unit's i_stock_id/i_data_valid/i_best_ask/i_best_bid inputs.

Parameters:
DATA_WIDTH, 32, price width
NUM_STOCKS, 4, number of stocks; stock id width SW = $clog2(NUM_STOCKS)
NUM_REQ, 2, number of requesters (>=2); grant id width GW = $clog2(NUM_REQ)
HAZARD_CYCLES, 3, same-stock lockout after issue; 0 disables locking

Ports:
i_clk  input  1  clock, all logic on rising edge
i_reset  input  1  synchronous active-high reset
i_pause  input  1  downstream stall; no grants while high
i_req_valid  input  NUM_REQ  per-requester valid
o_req_ready  output  NUM_REQ  per-requester ready, one-hot or zero, combinational
i_req_stock_id  input  NUM_REQ*SW  packed stock ids, requester r at [r*SW +: SW]
i_req_best_ask  input  NUM_REQ*DATA_WIDTH  packed best ask
i_req_best_bid  input  NUM_REQ*DATA_WIDTH  packed best bid
o_data_valid  output  1  issued update valid, one cycle per grant
o_stock_id  output  SW  issued stock id
o_best_ask  output  DATA_WIDTH  issued best ask
o_best_bid  output  DATA_WIDTH  issued best bid
o_grant_id  output  GW  requester index of issued update
o_stock_locked  output  NUM_STOCKS  per-stock lock status (counter != 0)

Behaviour:
- Reset (i_reset high at an edge): o_data_valid, o_stock_id, o_best_ask, o_best_bid, o_grant_id = 0; all lock counters = 0; RR pointer = 0. o_req_ready forced to 0 combinationally while i_reset is high. In-flight output is dropped.
- Handshake: valid/ready. A requester holds valid and payload stable until ready. Transfer occurs at the edge where valid && ready.
- Eligibility of r: i_req_valid[r] && lock_cnt[stock_id_r] == 0 && !i_pause && !i_reset.
- Arbitration: search eligible requesters starting at RR pointer, ascending with wrap. First hit r gets o_req_ready[r]=1; all others 0. No eligible requester means no grant.
- RR pointer: updates only on grant, to (r+1) mod NUM_REQ. Otherwise it holds.
- Output register: on grant at edge E, o_data_valid=1 after E, with the payload and o_grant_id of r. If there is no grant at an edge, o_data_valid=0 after that edge and the payload regs hold their last values. Latency is 1 cycle from handshake to output.
- Locking (HAZARD_CYCLES > 0):
  - Granted stock's counter loads HAZARD_CYCLES at the grant edge.
  - Every other nonzero counter decrements by 1 per edge, saturating at 0.
  - Load has priority over decrement for the same stock (cannot coincide in practice, since a locked stock is not grantable).
  - Minimum spacing between two issues of the same stock is HAZARD_CYCLES+1 cycles.
  - Counter width is $clog2(HAZARD_CYCLES+1).
- HAZARD_CYCLES=0: no counters are generated, o_stock_locked=0, and back-to-back same-stock issue is allowed.
- Several requesters on the same stock: only one is granted. The others wait and remain eligible once the lock expires.
- Different stocks are never blocked by each other's locks.
- i_pause: suppresses grants only. Lock counters keep decrementing and the output register still clears o_data_valid.
- Stock ids >= NUM_STOCKS (non-power-of-2 NUM_STOCKS): the request is never granted. Verification asserts this condition never occurs.

Test Plan:
- Single requester: req0 valid, stock 2, ask 105, bid 100 at cycle 0 -> ready0=1 in cycle 0; cycle 1 o_data_valid=1, o_stock_id=2, o_best_ask=105, o_best_bid=100, o_grant_id=0; o_stock_locked=4'b0100 for cycles 1-3, clear in cycle 4.
- Round-robin: req0 and req1 held valid on stocks 0 and 1, with new stocks after each grant so no lock blocks -> grants alternate 0,1,0,1 starting at 0. Over 8 grants each requester receives exactly 4.
- Same-stock hazard: req0 and req1 both valid on stock 3 at cycle 0 -> req0 granted in cycle 0, req1 ready only in cycle 4; o_data_valid high in cycles 1 and 5, low in 2-4.
- Mixed hazard: req0 on stock 1 granted at cycle 0, then req0 on stock 1 again while req1 on stock 2 -> req1 granted in cycle 1 with no stall; req0 is granted in cycle 4.
- Pause: i_pause high cycles 2-5 with both requesters valid -> no ready and o_data_valid=0 in cycles 3-6; locks keep counting down; grants resume in cycle 6 at the pointer held since before the pause.
- Reset mid-operation: assert i_reset in cycle 2 right after a grant, with stock 0 locked -> after the edge all outputs are 0, o_stock_locked=0 and the pointer is 0; a request on stock 0 is granted in the first cycle after reset deasserts.
